// File: rtl/touch_pkg.sv
// Shared constants, state encodings and small helpers for the LTM touch-panel sampler.
package touch_pkg;

  localparam logic [7:0] CMD_X      = 8'h90;  // 12-bit, differential, PD=00
  localparam logic [7:0] CMD_Y      = 8'hD0;
  localparam int         FRAME_BITS = 24;
  localparam int         COORD_W    = 12;

  localparam logic [1:0] ADDR_X      = 2'd0;
  localparam logic [1:0] ADDR_Y      = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_XFER_X,
    ST_XFER_Y,
    ST_LATCH,
    ST_GAP
  } seq_state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_CLOCK,
    PH_HOLD,
    PH_CS_HIGH
  } xfer_phase_e;

  // The conversion result sits one bit after the busy slot of the last 16 received bits.
  function automatic logic [COORD_W-1:0] frame_result(input logic [15:0] rx);
    return rx[14:3];
  endfunction

  function automatic logic [COORD_W-1:0] avg2(input logic [COORD_W-1:0] a,
                                             input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W:1];
  endfunction

endpackage

// File: rtl/touch_spi_xfer.sv
// One 24-SCLK ADS7843 frame: command byte out MSB first, 12-bit conversion result in.
module touch_spi_xfer
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [7:0]         cmd,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] result,
  output logic               spi_cs_n,
  output logic               spi_sclk,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  xfer_phase_e                 phase_q, phase_d;
  logic [DIV_W-1:0]            div_cnt_q;
  logic [4:0]                  bit_cnt_q;
  logic [FRAME_BITS-1:0]       tx_q;
  logic [15:0]                 rx_q;
  logic                        tick;
  logic                        last_bit;
  logic                        unused_rx;

  assign tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign last_bit  = (bit_cnt_q == 5'(FRAME_BITS - 1));
  assign busy      = (phase_q != PH_IDLE);
  assign unused_rx = ^{rx_q[15], rx_q[2:0]};

  // NOTE: async reset sits in the sensitivity list so a mid-frame reset releases the bus at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= PH_IDLE;
    else          phase_q <= phase_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PH_IDLE:    if (start) phase_d = PH_SETUP;
      PH_SETUP:   if (tick) phase_d = PH_CLOCK;
      PH_CLOCK:   if (tick && spi_sclk && last_bit) phase_d = PH_HOLD;
      PH_HOLD:    if (tick) phase_d = PH_CS_HIGH;
      PH_CS_HIGH: if (tick) phase_d = PH_IDLE;
      default:    phase_d = PH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      if (phase_q == PH_IDLE || tick) div_cnt_q <= '0;
      else                            div_cnt_q <= div_cnt_q + 1'b1;

      unique case (phase_q)
        PH_IDLE: begin
          if (start) begin
            // First command bit must be stable before the first rising edge.
            spi_cs_n  <= 1'b0;
            spi_mosi  <= cmd[7];
            tx_q      <= {cmd[6:0], {(FRAME_BITS - 7){1'b0}}};
            bit_cnt_q <= '0;
          end
        end
        PH_SETUP: begin
          if (tick) begin
            spi_sclk <= 1'b1;
            rx_q     <= {rx_q[14:0], spi_miso};
          end
        end
        PH_CLOCK: begin
          if (tick) begin
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              rx_q     <= {rx_q[14:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              spi_mosi <= tx_q[FRAME_BITS-1];
              tx_q     <= {tx_q[FRAME_BITS-2:0], 1'b0};
              if (!last_bit) bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        PH_HOLD: begin
          if (tick) spi_cs_n <= 1'b1;
        end
        PH_CS_HIGH: begin
          if (tick) begin
            done   <= 1'b1;
            result <= frame_result(rx_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ltm_touch_sampler.sv
// ADS7843 touch sampler: pen debounce, X/Y frame sequencing and Avalon-MM register file.
// Define TOUCH_AVG_EN to take two frames per axis and report their truncated mean.
module ltm_touch_sampler
  import touch_pkg::*;
#(
  parameter int CLK_DIV      = 25,
  parameter int DEBOUNCE_CYC = 5000,
  parameter int SAMPLE_GAP   = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        touch_evt,
  input  logic        penirq_n,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int CNT_W = (GAP_W > DEB_W) ? GAP_W : DEB_W;

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               pen_meta_q, pen_s;
  logic               xfer_start, xfer_busy, xfer_done;
  logic [7:0]         xfer_cmd;
  logic [COORD_W-1:0] xfer_result;
  logic [COORD_W-1:0] x_new_q, y_new_q, x_q, y_q;
  logic               valid_q, overrun_q, enable_q;
  logic               bus_wr, bus_rd, latch;
  logic [31:0]        rd_mux;
  logic               unused_wdata;
  logic               unused_busy;
`ifdef TOUCH_AVG_EN
  logic [COORD_W-1:0] first_q;
  logic               second_q;
`endif

  assign bus_wr       = chipselect && !write_n;
  assign bus_rd       = chipselect && write_n;
  assign latch        = (state_q == ST_LATCH);
  assign unused_wdata = ^writedata[31:3];
  assign unused_busy  = xfer_busy;

  // penirq_n is asynchronous to clk; reset to the pen-up level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pen_meta_q <= 1'b1;
      pen_s      <= 1'b1;
    end else begin
      pen_meta_q <= penirq_n;
      pen_s      <= pen_meta_q;
    end
  end

  touch_spi_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (xfer_start),
    .cmd      (xfer_cmd),
    .busy     (xfer_busy),
    .done     (xfer_done),
    .result   (xfer_result),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)                             cnt_q <= '0;
      else if (state_q == ST_DEBOUNCE || state_q == ST_GAP) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Frames are launched on the transition into (or re-entry of) an XFER state.
  always_comb begin
    state_d    = state_q;
    xfer_start = 1'b0;
    unique case (state_q)
      ST_IDLE: if (enable_q && !pen_s) state_d = ST_DEBOUNCE;
      ST_DEBOUNCE: begin
        if (pen_s) state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
          state_d    = ST_XFER_X;
          xfer_start = 1'b1;
        end
      end
      ST_XFER_X: begin
        if (xfer_done) begin
          xfer_start = 1'b1;
`ifdef TOUCH_AVG_EN
          if (second_q) state_d = ST_XFER_Y;
`else
          state_d = ST_XFER_Y;
`endif
        end
      end
      ST_XFER_Y: begin
        if (xfer_done) begin
`ifdef TOUCH_AVG_EN
          if (second_q) state_d = ST_LATCH;
          else          xfer_start = 1'b1;
`else
          state_d = ST_LATCH;
`endif
        end
      end
      ST_LATCH: state_d = enable_q ? ST_GAP : ST_IDLE;
      ST_GAP: begin
        if (pen_s) state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(SAMPLE_GAP - 1)) begin
          if (enable_q) begin
            state_d    = ST_XFER_X;
            xfer_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    xfer_cmd = (state_d == ST_XFER_Y) ? CMD_Y : CMD_X;
  end

  // Per-axis sample capture; the pair is only published to the CPU in LATCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_new_q  <= '0;
      y_new_q  <= '0;
`ifdef TOUCH_AVG_EN
      first_q  <= '0;
      second_q <= 1'b0;
`endif
    end else if (xfer_done && (state_q == ST_XFER_X || state_q == ST_XFER_Y)) begin
`ifdef TOUCH_AVG_EN
      if (!second_q) begin
        first_q  <= xfer_result;
        second_q <= 1'b1;
      end else begin
        second_q <= 1'b0;
        if (state_q == ST_XFER_X) x_new_q <= avg2(first_q, xfer_result);
        else                      y_new_q <= avg2(first_q, xfer_result);
      end
`else
      if (state_q == ST_XFER_X) x_new_q <= xfer_result;
      else                      y_new_q <= xfer_result;
`endif
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_X:      rd_mux = {{(32 - COORD_W){1'b0}}, x_q};
      ADDR_Y:      rd_mux = {{(32 - COORD_W){1'b0}}, y_q};
      ADDR_STATUS: rd_mux = {29'b0, overrun_q, valid_q, ~pen_s};
      ADDR_CTRL:   rd_mux = {31'b0, enable_q};
      default:     rd_mux = '0;
    endcase
  end

  // LATCH takes priority over a same-cycle CPU clear of valid or overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      enable_q  <= 1'b1;
      touch_evt <= 1'b0;
      readdata  <= '0;
    end else begin
      touch_evt <= (state_d == ST_LATCH);
      if (latch) begin
        x_q     <= x_new_q;
        y_q     <= y_new_q;
        valid_q <= 1'b1;
      end else if (bus_wr && address == ADDR_STATUS && writedata[1]) begin
        valid_q <= 1'b0;
      end
      if (latch && valid_q)                                      overrun_q <= 1'b1;
      else if (bus_wr && address == ADDR_STATUS && writedata[2]) overrun_q <= 1'b0;
      if (bus_wr && address == ADDR_CTRL) enable_q <= writedata[0];
      if (bus_rd) readdata <= rd_mux;
    end
  end

endmodule
